// File: rtl/connect4_move_sequencer_if.sv
// Board-array and win-checker bus of the Connect-4 move sequencer.
// The sequencer is the master: it drives board reads and writes and starts the checker.
interface connect4_move_sequencer_if;
    logic [2:0] rd_row;
    logic [2:0] rd_col;
    logic [1:0] rd_data;
    logic       wr_en;
    logic [2:0] wr_row;
    logic [2:0] wr_col;
    logic [1:0] wr_data;
    logic       board_clr;
    logic       chk_start;
    logic       chk_done;
    logic       chk_win;

    modport master (
        output rd_row, rd_col, wr_en, wr_row, wr_col, wr_data, board_clr, chk_start,
        input  rd_data, chk_done, chk_win
    );

    modport slave (
        input  rd_row, rd_col, wr_en, wr_row, wr_col, wr_data, board_clr, chk_start,
        output rd_data, chk_done, chk_win
    );
endinterface

// File: rtl/connect4_move_sequencer.sv
// Connect-4 turn/move controller: cursor, bottom-up column scan, piece write, win-check handshake.
// Optional macro AUTO_DROP_EN: a turn timeout drops a piece at the cursor instead of forfeiting.
module connect4_move_sequencer #(
    parameter int ROWS      = 6,
    parameter int COLS      = 7,
    parameter int START_COL = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       new_game,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       move_made,
    input  logic       turn_timeout,
    connect4_move_sequencer_if.master bus,
    output logic [2:0] cursor_col,
    output logic       player_turn,
    output logic       turn_restart,
    output logic [5:0] moves,
    output logic [2:0] state,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       col_full
);

    typedef enum logic [2:0] {
        S_CLEAR  = 3'd0,
        S_SELECT = 3'd1,
        S_SCAN   = 3'd2,
        S_WRITE  = 3'd3,
        S_CHECK  = 3'd4,
        S_SWITCH = 3'd5,
        S_WIN    = 3'd6,
        S_DRAW   = 3'd7
    } state_t;

    localparam logic [5:0] CELLS    = 6'(ROWS * COLS);
    localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);
    localparam logic [2:0] LAST_COL = 3'(COLS - 1);
    localparam logic [2:0] HOME_COL = 3'(START_COL);

    state_t     state_reg, state_next;
    logic [2:0] cursor_reg, cursor_next;
    logic       player_reg, player_next;
    logic [5:0] moves_reg, moves_next;
    logic [1:0] winner_reg, winner_next;
    logic [2:0] drop_col_reg, drop_col_next;
    logic [2:0] row_reg, row_next;
    logic       run_reg, run_next;
    logic       chk_busy_reg, chk_busy_next;
    logic       auto_reg, auto_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_CLEAR;
            cursor_reg   <= HOME_COL;
            player_reg   <= 1'b0;
            moves_reg    <= '0;
            winner_reg   <= '0;
            drop_col_reg <= '0;
            row_reg      <= '0;
            run_reg      <= 1'b0;
            chk_busy_reg <= 1'b0;
            auto_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cursor_reg   <= cursor_next;
            player_reg   <= player_next;
            moves_reg    <= moves_next;
            winner_reg   <= winner_next;
            drop_col_reg <= drop_col_next;
            row_reg      <= row_next;
            run_reg      <= run_next;
            chk_busy_reg <= chk_busy_next;
            auto_reg     <= auto_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cursor_next   = cursor_reg;
        player_next   = player_reg;
        moves_next    = moves_reg;
        winner_next   = winner_reg;
        drop_col_next = drop_col_reg;
        row_next      = row_reg;
        run_next      = 1'b1;
        chk_busy_next = 1'b0;
        auto_next     = auto_reg;
        bus.board_clr = 1'b0;
        bus.wr_en     = 1'b0;
        bus.chk_start = 1'b0;
        turn_restart  = 1'b0;
        col_full      = 1'b0;

        case (state_reg)
            // The first cycle after reset release only arms run_reg, so the
            // clear pulses never overlap the reset itself.
            S_CLEAR: begin
                if (run_reg) begin
                    bus.board_clr = 1'b1;
                    turn_restart  = 1'b1;
                    state_next    = S_SELECT;
                end
            end
            S_SELECT: begin
                if (move_made) begin
                    drop_col_next = cursor_reg;
                    row_next      = LAST_ROW;
                    auto_next     = 1'b0;
                    state_next    = S_SCAN;
                end else if (turn_timeout) begin
`ifdef AUTO_DROP_EN
                    drop_col_next = cursor_reg;
                    row_next      = LAST_ROW;
                    auto_next     = 1'b1;
                    state_next    = S_SCAN;
`else
                    state_next    = S_SWITCH;
`endif
                end else if (move_left && !move_right) begin
                    if (cursor_reg != 3'd0) cursor_next = cursor_reg - 3'd1;
                end else if (move_right && !move_left) begin
                    if (cursor_reg != LAST_COL) cursor_next = cursor_reg + 3'd1;
                end
            end
            S_SCAN: begin
                if (bus.rd_data == 2'b00) begin
                    state_next = S_WRITE;
                end else if (row_reg != 3'd0) begin
                    row_next = row_reg - 3'd1;
                end else if (auto_reg) begin
                    state_next = S_SWITCH;
                end else begin
                    col_full   = 1'b1;
                    state_next = S_SELECT;
                end
            end
            S_WRITE: begin
                bus.wr_en = 1'b1;
                if (moves_reg < CELLS) moves_next = moves_reg + 6'd1;
                state_next = S_CHECK;
            end
            S_CHECK: begin
                bus.chk_start = !chk_busy_reg;
                chk_busy_next = 1'b1;
                if (bus.chk_done) begin
                    chk_busy_next = 1'b0;
                    if (bus.chk_win) begin
                        winner_next = player_reg ? 2'b10 : 2'b01;
                        state_next  = S_WIN;
                    end else if (moves_reg == CELLS) begin
                        state_next = S_DRAW;
                    end else begin
                        state_next = S_SWITCH;
                    end
                end
            end
            S_SWITCH: begin
                player_next  = !player_reg;
                turn_restart = 1'b1;
                state_next   = S_SELECT;
            end
            default: ;
        endcase

        if (new_game) begin
            state_next    = S_CLEAR;
            moves_next    = '0;
            winner_next   = '0;
            player_next   = 1'b0;
            cursor_next   = HOME_COL;
            chk_busy_next = 1'b0;
        end
    end

    assign bus.rd_row  = row_reg;
    assign bus.rd_col  = drop_col_reg;
    assign bus.wr_row  = row_reg;
    assign bus.wr_col  = drop_col_reg;
    assign bus.wr_data = player_reg ? 2'b10 : 2'b01;
    assign cursor_col  = cursor_reg;
    assign player_turn = player_reg;
    assign moves       = moves_reg;
    assign state       = state_reg;
    assign winner      = winner_reg;
    assign game_over   = (state_reg == S_WIN) || (state_reg == S_DRAW);

endmodule
